st_serializer: RTL and testbench
================================

ST_SERIALIZER -- requirements
Module: st_serializer

Interface
REQ-001 Parameter IN_BYTES, default 4, SHALL give the input beat width in bytes (legal 2..16).
REQ-002 Port clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port in  avalon_st_if sink (DATA_WIDTH_IN_BYTES=IN_BYTES)  SHALL accept data/vld/sop/eop/empty and drive rdy; the FIFO read side connects here.
REQ-005 Port out  avalon_st_if source (DATA_WIDTH_IN_BYTES=1)  SHALL drive data/vld/sop/eop, hold empty at 0 and consume rdy.
REQ-006 Port busy  output  1  SHALL be high while a captured beat still has bytes left to emit.

Function
REQ-007 Beat transfer on either side SHALL occur only on a clock edge with vld and rdy both high.
REQ-008 Byte order SHALL be Avalon symbol order: byte 0 = in.data[8*IN_BYTES-1 -: 8], emitted first.
REQ-009 States SHALL be IDLE (no beat held) and SHIFT (beat held, index idx, last index lst).
REQ-010 IDLE: in.rdy SHALL be 1; on in transfer capture data/sop/eop, idx<=0, lst<=eop ? IN_BYTES-1-empty : IN_BYTES-1, go SHIFT.
REQ-011 SHIFT: out.vld SHALL be 1, out.data = byte idx of held beat; on out transfer with idx<lst, idx<=idx+1.
REQ-012 SHIFT, out transfer with idx==lst: if in.vld, capture the next beat in the same cycle (zero bubble, stay SHIFT); else go IDLE.
REQ-013 in.rdy SHALL equal (state==IDLE) || (out.rdy && idx==lst), combinationally; no other path from out.rdy to in.rdy.
REQ-014 out.sop SHALL be 1 only on byte 0 of a beat captured with sop=1.
REQ-015 out.eop SHALL be 1 only on byte lst of a beat captured with eop=1.
REQ-016 in.empty on a beat with eop=0 SHALL be ignored (all IN_BYTES bytes emitted).
REQ-017 in.empty >= IN_BYTES on an eop beat SHALL be clamped to IN_BYTES-1 (one byte emitted).
REQ-018 Latency SHALL be exactly 1 cycle from in transfer to first out byte valid.
REQ-019 Throughput SHALL be 1 byte/cycle sustained while out.rdy=1 and in.vld=1.
REQ-020 While out.vld=1 and out.rdy=0, out.data/sop/eop SHALL stay stable.
REQ-021 Packet framing errors (sop without prior eop, eop without sop) SHALL pass through unmodified; no checking.
REQ-022 busy SHALL equal (state==SHIFT).

Reset
REQ-023 With rst=1 at a clock edge: state<=IDLE, idx<=0, lst<=0, held beat cleared.
REQ-024 During and after reset: out.vld=0, out.sop=0, out.eop=0, out.data=0, busy=0, in.rdy=1 from the first cycle after rst falls.
REQ-025 in.rdy SHALL be 0 while rst=1 so no beat is accepted during reset.
REQ-026 Reset mid-beat SHALL discard remaining bytes; no partial packet completion after reset.

Structure
REQ-027 The state enum (IDLE, SHIFT) and a BYTE_W=8 constant SHALL live in fifo_pack.
REQ-028 Index widths SHALL be $clog2(IN_BYTES), derived in the module.
REQ-029 No sub-module; the byte-select mux SHALL be inline.
REQ-030 RTL size SHALL be within 120-400 lines.

Verification (IN_BYTES=4)
REQ-031 Single beat 0xAABBCCDD sop=1 eop=1 empty=0, out.rdy=1 -> bytes AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept; sop on AA, eop on DD.
REQ-032 Two-beat packet 0x01020304 (sop) then 0x05060000 (eop, empty=2), in.vld continuous, out.rdy=1 -> 01..06 on 6 back-to-back cycles, no gap, eop on 06.
REQ-033 out.rdy toggled 1,0,1,0 during a beat -> each byte held stable while rdy=0; in.rdy stays 0 until last byte transfers.
REQ-034 eop beat with empty=7 -> exactly one byte (MSB) emitted with sop/eop as captured.
REQ-035 rst=1 asserted while idx=2 -> next cycle out.vld=0, busy=0; after release a new beat starts at byte 0.
REQ-036 Chained with fifo (FIFO_DEPTH=2) and random out.rdy over 1000 beats -> byte stream equals reference model, no loss or duplication.

Source files
------------

// File: rtl/fifo_pack.sv
// Shared definitions for the streaming byte path.
//   BYTE_W  : width of one Avalon symbol.
//   state_e : serializer control state (IDLE = no beat held, SHIFT = beat held).
//   empty_w : width of an Avalon-ST empty field for a given symbol count. One
//             bit wider than log2 so that out-of-range empty values can be
//             presented and then clamped by the consumer.
package fifo_pack;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int empty_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon streaming bundle.
//   data  : DATA_WIDTH_IN_BYTES symbols, symbol 0 in the most significant byte
//   vld   : source has a beat
//   rdy   : sink accepts the beat (transfer when vld && rdy at a clock edge)
//   sop   : first beat of a packet
//   eop   : last beat of a packet
//   empty : unused symbols in an eop beat, counted from the least significant end
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 1
);
  localparam int DW = fifo_pack::BYTE_W * DATA_WIDTH_IN_BYTES;
  localparam int EW = fifo_pack::empty_w(DATA_WIDTH_IN_BYTES);

  logic [DW-1:0] data;
  logic          vld;
  logic          rdy;
  logic          sop;
  logic          eop;
  logic [EW-1:0] empty;

  modport sink   (input data, vld, sop, eop, empty, output rdy);
  modport source (output data, vld, sop, eop, empty, input rdy);

endinterface

// File: rtl/st_serializer.sv
// Wide-to-byte Avalon-ST serializer. Captures one IN_BYTES-wide beat and emits
// it one byte per cycle, most significant byte first, keeping packet framing.
// A new beat is accepted in the same cycle the last byte of the previous beat
// leaves, so a continuous input stream produces a gap-free byte stream.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   in   : avalon_st_if sink, IN_BYTES wide
//   out  : avalon_st_if source, 1 byte wide (empty tied to 0)
//   busy : a captured beat still has bytes left to emit
module st_serializer
  import fifo_pack::*;
#(
  parameter int IN_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.sink   in,
  avalon_st_if.source out,
  output logic        busy
);

  localparam int DATA_W  = BYTE_W * IN_BYTES;
  localparam int IDX_W   = $clog2(IN_BYTES);
  localparam int EMPTY_W = empty_w(IN_BYTES);

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [IDX_W-1:0]  lst, lst_nxt;
  logic [DATA_W-1:0] held;
  logic              held_sop, held_eop;
  logic              capture, at_last, in_rdy, in_xfer, out_xfer;
  logic [BYTE_W-1:0] byte_sel;

  // Index of the last byte to emit. Empty only matters on an eop beat, and an
  // empty that would leave no bytes saturates to a single-byte beat.
  function automatic logic [IDX_W-1:0] last_idx(input logic eop,
                                                 input logic [EMPTY_W-1:0] empty);
    logic [IDX_W-1:0] res;
    if (!eop)
      res = IDX_W'(IN_BYTES - 1);
    else if (int'(empty) >= IN_BYTES)
      res = '0;
    else
      res = IDX_W'(IN_BYTES - 1 - int'(empty));
    return res;
  endfunction

  assign busy     = (state == SHIFT);
  assign at_last  = (idx == lst);
  // The only out.rdy -> in.rdy path: the last byte leaving frees the holder.
  assign in_rdy   = !rst && ((state == IDLE) || (out.rdy && at_last));
  assign in.rdy   = in_rdy;
  assign in_xfer  = in.vld && in_rdy;
  assign out_xfer = busy && out.rdy;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    lst_nxt   = lst;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (in_xfer) capture = 1'b1;
      end
      SHIFT: begin
        if (out_xfer) begin
          if (!at_last)     idx_nxt   = idx + IDX_W'(1);
          else if (in_xfer) capture   = 1'b1;
          else              state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (capture) begin
      state_nxt = SHIFT;
      idx_nxt   = '0;
      lst_nxt   = last_idx(in.eop, in.empty);
    end
  end

  always_comb begin
    byte_sel = '0;
    for (int b = 0; b < IN_BYTES; b++) begin
      if (idx == IDX_W'(b)) byte_sel = held[DATA_W-1-BYTE_W*b -: BYTE_W];
    end
  end

  // Outputs are forced to zero whenever no beat is held.
  assign out.vld   = busy;
  assign out.data  = busy ? byte_sel : '0;
  assign out.sop   = busy && held_sop && (idx == '0);
  assign out.eop   = busy && held_eop && at_last;
  assign out.empty = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      lst      <= '0;
      held     <= '0;
      held_sop <= 1'b0;
      held_eop <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      lst   <= lst_nxt;
      if (capture) begin
        held     <= in.data;
        held_sop <= in.sop;
        held_eop <= in.eop;
      end
    end
  end

endmodule

// File: tb/tb_st_serializer.sv
module tb_st_serializer;

  localparam int NB = 300;

  logic clk;
  logic rst;
  logic busy;
  int   tests = 0;
  int   fails = 0;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(1)) out_if ();

  st_serializer #(.IN_BYTES(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in_if),
    .out  (out_if),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic s, input logic e);
    chk({tag, "_vld"},  32'(out_if.vld),  32'(v));
    chk({tag, "_data"}, 32'(out_if.data), 32'(d));
    chk({tag, "_sop"},  32'(out_if.sop),  32'(s));
    chk({tag, "_eop"},  32'(out_if.eop),  32'(e));
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic s, input logic e,
                            input logic [2:0] emp);
    in_if.data  = d;
    in_if.sop   = s;
    in_if.eop   = e;
    in_if.empty = emp;
    in_if.vld   = 1'b1;
  endtask

  logic [9:0]  expq[$];
  logic [9:0]  expv;
  int          beats_sent;
  int          nbytes;
  logic        acc;

  initial begin
    rst        = 1'b1;
    in_if.vld  = 1'b0;
    in_if.data = '0;
    in_if.sop  = 1'b0;
    in_if.eop  = 1'b0;
    in_if.empty = '0;
    out_if.rdy = 1'b1;

    // reset behaviour
    tick();
    tick();
    chk("rst_in_rdy", 32'(in_if.rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_out("rst", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_rdy", 32'(in_if.rdy), 32'd1);
    chk("out_empty", 32'(out_if.empty), 32'd0);

    // single beat, full packet
    drive_beat(32'hAABBCCDD, 1'b1, 1'b1, 3'd0);
    #1;
    chk("t1_in_rdy", 32'(in_if.rdy), 32'd1);
    tick();
    in_if.vld = 1'b0;
    #1;
    chk_out("t1_b0", 1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_rdy_b0", 32'(in_if.rdy), 32'd0);
    tick();
    chk_out("t1_b1", 1'b1, 8'hBB, 1'b0, 1'b0);
    tick();
    chk_out("t1_b2", 1'b1, 8'hCC, 1'b0, 1'b0);
    tick();
    chk_out("t1_b3", 1'b1, 8'hDD, 1'b0, 1'b1);
    chk("t1_in_rdy_b3", 32'(in_if.rdy), 32'd1);
    tick();
    chk_out("t1_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // two-beat packet, zero bubble between beats
    drive_beat(32'h01020304, 1'b1, 1'b0, 3'd0);
    #1;
    tick();
    drive_beat(32'h05060000, 1'b0, 1'b1, 3'd2);
    #1;
    chk_out("t2_b0", 1'b1, 8'h01, 1'b1, 1'b0);
    chk("t2_in_rdy_b0", 32'(in_if.rdy), 32'd0);
    tick();
    chk_out("t2_b1", 1'b1, 8'h02, 1'b0, 1'b0);
    tick();
    chk_out("t2_b2", 1'b1, 8'h03, 1'b0, 1'b0);
    tick();
    chk_out("t2_b3", 1'b1, 8'h04, 1'b0, 1'b0);
    chk("t2_in_rdy_b3", 32'(in_if.rdy), 32'd1);
    tick();
    in_if.vld = 1'b0;
    #1;
    chk_out("t2_b4", 1'b1, 8'h05, 1'b0, 1'b0);
    tick();
    chk_out("t2_b5", 1'b1, 8'h06, 1'b0, 1'b1);
    tick();
    chk_out("t2_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // backpressure: bytes hold while out.rdy is low
    drive_beat(32'h11223344, 1'b1, 1'b1, 3'd0);
    #1;
    tick();
    in_if.vld  = 1'b0;
    out_if.rdy = 1'b0;
    #1;
    chk_out("t3_hold0a", 1'b1, 8'h11, 1'b1, 1'b0);
    chk("t3_in_rdy_hold", 32'(in_if.rdy), 32'd0);
    tick();
    chk_out("t3_hold0b", 1'b1, 8'h11, 1'b1, 1'b0);
    out_if.rdy = 1'b1;
    #1;
    tick();
    out_if.rdy = 1'b0;
    #1;
    chk_out("t3_hold1a", 1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    chk_out("t3_hold1b", 1'b1, 8'h22, 1'b0, 1'b0);
    out_if.rdy = 1'b1;
    #1;
    tick();
    chk_out("t3_b2", 1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    out_if.rdy = 1'b0;
    #1;
    chk_out("t3_b3", 1'b1, 8'h44, 1'b0, 1'b1);
    chk("t3_in_rdy_last_stall", 32'(in_if.rdy), 32'd0);
    out_if.rdy = 1'b1;
    #1;
    chk("t3_in_rdy_last_go", 32'(in_if.rdy), 32'd1);
    tick();
    chk_out("t3_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // oversized empty clamps to one byte
    drive_beat(32'h9A8B7C6D, 1'b1, 1'b1, 3'd7);
    #1;
    tick();
    in_if.vld = 1'b0;
    #1;
    chk_out("t4_b0", 1'b1, 8'h9A, 1'b1, 1'b1);
    chk("t4_in_rdy", 32'(in_if.rdy), 32'd1);
    tick();
    chk_out("t4_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // empty ignored without eop
    drive_beat(32'h55667788, 1'b0, 1'b0, 3'd3);
    #1;
    tick();
    in_if.vld = 1'b0;
    #1;
    chk_out("t5_b0", 1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk_out("t5_b3", 1'b1, 8'h88, 1'b0, 1'b0);
    tick();
    chk_out("t5_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // reset in the middle of a beat
    drive_beat(32'hCAFEBABE, 1'b1, 1'b1, 3'd0);
    #1;
    tick();
    in_if.vld = 1'b0;
    tick();
    tick();
    chk_out("t6_b2", 1'b1, 8'hBA, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_in_rdy", 32'(in_if.rdy), 32'd0);
    tick();
    chk_out("t6_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    drive_beat(32'h12345678, 1'b1, 1'b1, 3'd0);
    #1;
    tick();
    in_if.vld = 1'b0;
    #1;
    chk_out("t6_new_b0", 1'b1, 8'h12, 1'b1, 1'b0);
    chk("t6_new_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    chk_out("t6_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // random backpressure and source gaps against a byte-queue model
    beats_sent = 0;
    for (int cyc = 0; cyc < 20000 && (beats_sent < NB || expq.size() > 0); cyc++) begin
      if (!in_if.vld && beats_sent < NB && $urandom_range(3) != 0)
        drive_beat(32'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   3'($urandom_range(7)));
      out_if.rdy = 1'($urandom_range(2) != 0);
      #1;
      if (out_if.vld && out_if.rdy) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL rnd_extra: got byte %0h expected none", out_if.data);
        end else begin
          expv = expq.pop_front();
          chk("rnd_byte", 32'({out_if.sop, out_if.eop, out_if.data}), 32'(expv));
        end
      end
      acc = in_if.vld && in_if.rdy;
      if (acc) begin
        if (!in_if.eop)           nbytes = 4;
        else if (in_if.empty >= 3'd4) nbytes = 1;
        else                      nbytes = 4 - int'(in_if.empty);
        for (int k = 0; k < nbytes; k++)
          expq.push_back({in_if.sop && (k == 0), in_if.eop && (k == nbytes - 1),
                          in_if.data[31-8*k -: 8]});
        beats_sent++;
      end
      tick();
      if (acc) in_if.vld = 1'b0;
    end
    chk("rnd_all_sent", 32'(beats_sent), 32'(NB));
    chk("rnd_drained", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
